intr_vector_ctrl: RTL and testbench

Vectored interrupt source for the MicroBlaze subsystem. The block collects up to N_SRC rising-edge event lines from fabric peripherals and latches them as pending. It presents one interrupt at a time to the processor's level-sensitive INTERRUPT port with a 32-bit vector address. It then tracks the processor's 2-bit acknowledge through accept and return-from-interrupt before it issues the next request.

---
 rtl/intr_vector_ctrl_if.sv | 28 ++
 rtl/intr_vector_ctrl.sv | 124 ++++++++++++
 tb/tb_intr_vector_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/intr_vector_ctrl_if.sv
// Purpose: bundles the event, mask, acknowledge and vector signals of intr_vector_ctrl.
// Ports: none; master = controller side (drives interrupt/vector/status),
//        slave = fabric/processor side (drives events, mask, ack, overrun clear).
interface intr_vector_ctrl_if #(
  parameter int unsigned N_SRC = 8
);
  localparam int unsigned ID_W = $clog2(N_SRC);

  logic [N_SRC-1:0] irq_src;
  logic [N_SRC-1:0] irq_mask;
  logic [1:0]       intr_ack;
  logic             ovr_clr;
  logic             interrupt;
  logic [31:0]      intr_address;
  logic [ID_W-1:0]  active_id;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] overrun;

  modport master (
    input  irq_src, irq_mask, intr_ack, ovr_clr,
    output interrupt, intr_address, active_id, pending, overrun
  );

  modport slave (
    output irq_src, irq_mask, intr_ack, ovr_clr,
    input  interrupt, intr_address, active_id, pending, overrun
  );
endinterface

// File: rtl/intr_vector_ctrl.sv
// Purpose: latches rising-edge events and dispatches them one at a time as a vectored level interrupt.
// Latency: event to pending 1 cycle, pending to interrupt 1 cycle; all outputs registered.
// Backpressure: next request waits for ack=01 (accept) then ack=10 (return); events keep latching meanwhile.
// Ports: sys_clk, ext_rst (sync, active-high); bus.master carries irq_src/irq_mask/intr_ack/ovr_clr in,
//        interrupt/intr_address/active_id/pending/overrun out.
module intr_vector_ctrl #(
  parameter int unsigned N_SRC      = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
  parameter int unsigned VEC_STRIDE = 16
) (
  input  logic               sys_clk,
  input  logic               ext_rst,
  intr_vector_ctrl_if.master bus
);
  localparam int unsigned ID_W = $clog2(N_SRC);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_SRC-1:0] r_src_q;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_overrun;
  logic             r_interrupt;
  logic [31:0]      r_addr;
  logic [ID_W-1:0]  r_id;

  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_eligible;
  logic [N_SRC-1:0] w_clr;
  logic             w_any;
  logic             w_accept;
  logic [ID_W-1:0]  w_sel;
  logic             w_irq_nxt;
  logic [31:0]      w_addr_nxt;
  logic [ID_W-1:0]  w_id_nxt;

  assign w_rise     = bus.irq_src & ~r_src_q;
  assign w_eligible = r_pending & bus.irq_mask;
  assign w_any      = |w_eligible;
  assign w_accept   = (r_state == S_ASSERT) && (bus.intr_ack == 2'b01);

  // Lowest index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    w_sel = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_sel = ID_W'(i);
    end
  end

  always_comb begin
    w_clr = '0;
    if (w_accept) w_clr[r_id] = 1'b1;
  end

  // Edge detector keeps sampling during reset so lines already high at release do not fire.
  // OR-ing w_rise last makes a new event win over an accept clear or an overrun clear.
  always_ff @(posedge sys_clk) begin
    r_src_q <= bus.irq_src;
    if (ext_rst) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_rise;
      r_overrun <= (bus.ovr_clr ? {N_SRC{1'b0}} : r_overrun) | (w_rise & r_pending);
    end
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (ext_rst) begin
      r_state     <= S_IDLE;
      r_interrupt <= 1'b0;
      r_addr      <= '0;
      r_id        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_interrupt <= w_irq_nxt;
      r_addr      <= w_addr_nxt;
      r_id        <= w_id_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_any) w_state_nxt = S_ASSERT;
      S_ASSERT:  if (w_accept) w_state_nxt = S_SERVICE;
      S_SERVICE: if (bus.intr_ack == 2'b10) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: vector and id are captured only on dispatch and held afterwards,
  // so a mask change during ASSERT cannot alter or withdraw the request.
  always_comb begin
    w_irq_nxt  = r_interrupt;
    w_addr_nxt = r_addr;
    w_id_nxt   = r_id;
    case (r_state)
      S_IDLE: begin
        w_irq_nxt = 1'b0;
        if (w_any) begin
          w_irq_nxt  = 1'b1;
          w_id_nxt   = w_sel;
          w_addr_nxt = BASE_ADDR + 32'(w_sel) * VEC_STRIDE;
        end
      end
      S_ASSERT: begin
        w_irq_nxt = 1'b1;
        if (w_accept) w_irq_nxt = 1'b0;
      end
      S_SERVICE: w_irq_nxt = 1'b0;
      default:   w_irq_nxt = 1'b0;
    endcase
  end

  assign bus.interrupt    = r_interrupt;
  assign bus.intr_address = r_addr;
  assign bus.active_id    = r_id;
  assign bus.pending      = r_pending;
  assign bus.overrun      = r_overrun;
endmodule

// File: tb/tb_intr_vector_ctrl.sv
// Purpose: directed scoreboard bench for intr_vector_ctrl (N_SRC=8, base 0x100, stride 16).
// Ports: none; drives the interface slave side, samples 1 time unit after each rising edge.
module tb_intr_vector_ctrl;
  logic sys_clk = 1'b0;
  logic ext_rst = 1'b1;

  intr_vector_ctrl_if #(.N_SRC(8)) bus ();

  intr_vector_ctrl #(
    .N_SRC(8),
    .BASE_ADDR(32'h0000_0100),
    .VEC_STRIDE(16)
  ) dut (
    .sys_clk(sys_clk),
    .ext_rst(ext_rst),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string       tag;
    logic        irq;
    logic [31:0] addr;
    logic [2:0]  id;
    logic [7:0]  pend;
    logic [7:0]  ovr;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    n_total++;
    assert (bus.interrupt === e.irq) n_pass++;
    else $error("FAIL %s.interrupt got %0b want %0b", e.tag, bus.interrupt, e.irq);
    n_total++;
    assert (bus.intr_address === e.addr) n_pass++;
    else $error("FAIL %s.intr_address got %h want %h", e.tag, bus.intr_address, e.addr);
    n_total++;
    assert (bus.active_id === e.id) n_pass++;
    else $error("FAIL %s.active_id got %0d want %0d", e.tag, bus.active_id, e.id);
    n_total++;
    assert (bus.pending === e.pend) n_pass++;
    else $error("FAIL %s.pending got %h want %h", e.tag, bus.pending, e.pend);
    n_total++;
    assert (bus.overrun === e.ovr) n_pass++;
    else $error("FAIL %s.overrun got %h want %h", e.tag, bus.overrun, e.ovr);
  endtask

  // Inputs have just been driven: queue what the DUT must show after the next edge, then compare.
  task automatic step(input string tag, input logic irq, input logic [31:0] addr,
                      input logic [2:0] id, input logic [7:0] pend, input logic [7:0] ovr);
    exp_t e;
    e.tag = tag; e.irq = irq; e.addr = addr; e.id = id; e.pend = pend; e.ovr = ovr;
    sb.push_back(e);
    @(posedge sys_clk);
    #1;
    check_out();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.irq_src  = 8'h00;
    bus.irq_mask = 8'hFF;
    bus.intr_ack = 2'b00;
    bus.ovr_clr  = 1'b0;
    ext_rst      = 1'b1;
    @(posedge sys_clk);
    #1;
    step("reset", 0, 32'h0, 0, 8'h00, 8'h00);

    // Single event on source 3
    ext_rst = 1'b0; bus.irq_src = 8'h08;
    step("s1_pend", 0, 32'h0, 0, 8'h08, 8'h00);
    bus.irq_src = 8'h00;
    step("s1_irq", 1, 32'h130, 3, 8'h08, 8'h00);
    bus.intr_ack = 2'b01;
    step("s1_acc", 0, 32'h130, 3, 8'h00, 8'h00);
    bus.intr_ack = 2'b10;
    step("s1_ret", 0, 32'h130, 3, 8'h00, 8'h00);
    bus.intr_ack = 2'b00;
    step("s1_idle", 0, 32'h130, 3, 8'h00, 8'h00);

    // Priority: sources 5 and 1 together
    bus.irq_src = 8'h22;
    step("pr_pend", 0, 32'h130, 3, 8'h22, 8'h00);
    bus.irq_src = 8'h00;
    step("pr_src1", 1, 32'h110, 1, 8'h22, 8'h00);
    bus.intr_ack = 2'b01;
    step("pr_acc1", 0, 32'h110, 1, 8'h20, 8'h00);
    bus.intr_ack = 2'b10;
    step("pr_ret1", 0, 32'h110, 1, 8'h20, 8'h00);
    bus.intr_ack = 2'b00;
    step("pr_src5", 1, 32'h150, 5, 8'h20, 8'h00);
    bus.intr_ack = 2'b01;
    step("pr_acc5", 0, 32'h150, 5, 8'h00, 8'h00);
    bus.intr_ack = 2'b10;
    step("pr_ret5", 0, 32'h150, 5, 8'h00, 8'h00);
    bus.intr_ack = 2'b00;
    step("pr_idle", 0, 32'h150, 5, 8'h00, 8'h00);

    // Masking and handshake robustness in ASSERT
    bus.irq_mask = 8'h00; bus.irq_src = 8'h04;
    step("mk_pend", 0, 32'h150, 5, 8'h04, 8'h00);
    bus.irq_src = 8'h00;
    step("mk_hold", 0, 32'h150, 5, 8'h04, 8'h00);
    bus.irq_mask = 8'h04;
    step("mk_irq", 1, 32'h120, 2, 8'h04, 8'h00);
    bus.irq_mask = 8'h00;
    step("mk_unmask", 1, 32'h120, 2, 8'h04, 8'h00);
    bus.intr_ack = 2'b11;
    step("as_ack11", 1, 32'h120, 2, 8'h04, 8'h00);
    bus.intr_ack = 2'b10;
    step("as_ack10", 1, 32'h120, 2, 8'h04, 8'h00);
    bus.intr_ack = 2'b01;
    step("mk_acc", 0, 32'h120, 2, 8'h00, 8'h00);
    // ack=01 in SERVICE must neither clear pending nor move the FSM
    bus.irq_src = 8'h02;
    step("sv_ack01a", 0, 32'h120, 2, 8'h02, 8'h00);
    bus.irq_mask = 8'hFF;
    step("sv_ack01b", 0, 32'h120, 2, 8'h02, 8'h00);
    bus.intr_ack = 2'b10;
    step("sv_ret", 0, 32'h120, 2, 8'h02, 8'h00);
    bus.intr_ack = 2'b00; bus.irq_src = 8'h00;
    step("sv_redisp", 1, 32'h110, 1, 8'h02, 8'h00);
    bus.intr_ack = 2'b01;
    step("sv_acc", 0, 32'h110, 1, 8'h00, 8'h00);
    bus.intr_ack = 2'b10;
    step("sv_ret2", 0, 32'h110, 1, 8'h00, 8'h00);
    bus.intr_ack = 2'b00;
    step("sv_idle", 0, 32'h110, 1, 8'h00, 8'h00);

    // Overrun and clear
    bus.irq_mask = 8'h00; bus.irq_src = 8'h01;
    step("ov_first", 0, 32'h110, 1, 8'h01, 8'h00);
    bus.irq_src = 8'h00;
    step("ov_low", 0, 32'h110, 1, 8'h01, 8'h00);
    bus.irq_src = 8'h01;
    step("ov_second", 0, 32'h110, 1, 8'h01, 8'h01);
    bus.irq_src = 8'h00; bus.ovr_clr = 1'b1;
    step("ov_clr", 0, 32'h110, 1, 8'h01, 8'h00);
    bus.irq_src = 8'h01;
    step("ov_setwins", 0, 32'h110, 1, 8'h01, 8'h01);
    bus.irq_src = 8'h00;
    step("ov_clr2", 0, 32'h110, 1, 8'h01, 8'h00);
    bus.ovr_clr = 1'b0; bus.irq_mask = 8'h01;
    step("ov_irq0", 1, 32'h100, 0, 8'h01, 8'h00);
    bus.irq_src = 8'h01; bus.intr_ack = 2'b01;
    step("ov_acc_rise", 0, 32'h100, 0, 8'h01, 8'h01);
    bus.irq_src = 8'h00; bus.intr_ack = 2'b10;
    step("ov_ret", 0, 32'h100, 0, 8'h01, 8'h01);
    bus.intr_ack = 2'b00;
    step("ov_redisp", 1, 32'h100, 0, 8'h01, 8'h01);
    bus.intr_ack = 2'b01; bus.irq_src = 8'h04;
    step("ov_acc2", 0, 32'h100, 0, 8'h04, 8'h01);

    // Reset while in SERVICE, with lines held high through reset
    ext_rst = 1'b1; bus.irq_src = 8'hFF; bus.intr_ack = 2'b00;
    step("rs_abort", 0, 32'h0, 0, 8'h00, 8'h00);
    step("rs_hold", 0, 32'h0, 0, 8'h00, 8'h00);
    ext_rst = 1'b0; bus.intr_ack = 2'b10; bus.irq_mask = 8'hFF;
    step("rs_release", 0, 32'h0, 0, 8'h00, 8'h00);
    bus.intr_ack = 2'b00;
    step("rs_noeffect", 0, 32'h0, 0, 8'h00, 8'h00);
    bus.irq_src = 8'h00;
    step("rs_low", 0, 32'h0, 0, 8'h00, 8'h00);
    bus.irq_src = 8'h80;
    step("rs_pend7", 0, 32'h0, 0, 8'h80, 8'h00);
    bus.irq_src = 8'h00;
    step("rs_irq7", 1, 32'h170, 7, 8'h80, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
